// File: rtl/wrapper_pkg.sv
// wrapper_pkg: definitions shared by the FP unit bus wrappers (input and
// output side). It holds the FSM state encoding, the default bus width and
// the Moore output decode used by the input wrapper control FSM.
// The BUSY state is only reachable when WRAPPER_IN_BUSY_EN is defined.
package wrapper_pkg;

    // Default operand / bus width of the FP unit.
    localparam int WIDTH_DEFAULT = 32;

    // Handshake FSM states. The encoding is fixed so that both wrappers and
    // any debug tooling agree on the numeric values.
    typedef enum logic [2:0] {
        WAIT_A = 3'd0,
        CAPT_A = 3'd1,
        ACK_A  = 3'd2,
        WAIT_B = 3'd3,
        CAPT_B = 3'd4,
        ACK_B  = 3'd5,
        START  = 3'd6,
        BUSY   = 3'd7
    } state_t;

    // Control signals that are pure functions of the current state.
    typedef struct packed {
        logic load_a;
        logic load_b;
        logic in_accepted;
        logic start_fp;
        logic busy;
    } ctrl_t;

    // Moore decode: every control output depends only on the state register,
    // so nothing here can combinationally follow inReady or doneFP.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            CAPT_A:  c.load_a      = 1'b1;
            CAPT_B:  c.load_b      = 1'b1;
            ACK_A:   c.in_accepted = 1'b1;
            ACK_B:   c.in_accepted = 1'b1;
            START:   c.start_fp    = 1'b1;
            BUSY:    c.busy        = 1'b1;
            default: c             = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wrapper_in_dp.sv
// wrapper_in_dp: operand storage for the FP input wrapper. Two WIDTH-bit
// registers load from the shared bus when their enable is high and hold
// otherwise. No arithmetic is applied; data passes through unchanged.
module wrapper_in_dp
    import wrapper_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b
);

    // Operand A register: captures the bus only in CAPT_A, cleared on reset
    // so a reset mid-transfer leaves no stale partial pair behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_a <= '0;
        end else if (load_a) begin
            operand_a <= in_bus;
        end
    end

    // Operand B register: captures the bus only in CAPT_B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_b <= '0;
        end else if (load_b) begin
            operand_b <= in_bus;
        end
    end

endmodule

// File: rtl/wrapper_in_fp.sv
// wrapper_in_fp: input-side bus wrapper for the 32-bit FP unit.
// Receives operand A then operand B over one shared bus using a 4-phase
// inReady/inAccepted handshake, stores both, then pulses startFP for one
// cycle. Optional feature macro: WRAPPER_IN_BUSY_EN -- when defined, the
// wrapper waits in BUSY (busy=1) after START until doneFP is sampled high and
// accepts no new operand meanwhile; when undefined, START returns straight
// to WAIT_A, busy is tied low and doneFP is ignored.
module wrapper_in_fp
    import wrapper_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inReady,
    input  logic [WIDTH-1:0] InBus,
    input  logic             doneFP,
    output logic             inAccepted,
    output logic             startFP,
    output logic [WIDTH-1:0] OperandA,
    output logic [WIDTH-1:0] OperandB,
    output logic             busy
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // State register; reset drops any partially received operand pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d = state_q;
        ctrl    = decode_ctrl(state_q);
        case (state_q)
            WAIT_A: if (inReady)  state_d = CAPT_A;
            CAPT_A:               state_d = ACK_A;
            // inReady held high here keeps the ack up without re-capturing.
            ACK_A:  if (!inReady) state_d = WAIT_B;
            WAIT_B: if (inReady)  state_d = CAPT_B;
            CAPT_B:               state_d = ACK_B;
            ACK_B:  if (!inReady) state_d = START;
`ifdef WRAPPER_IN_BUSY_EN
            START:                state_d = BUSY;
            // New operands stay pending on the bus until the core is done.
            BUSY:   if (doneFP)   state_d = WAIT_A;
`else
            START:                state_d = WAIT_A;
            BUSY:                 state_d = WAIT_A;
`endif
            default:              state_d = WAIT_A;
        endcase
    end

    assign inAccepted = ctrl.in_accepted;
    assign startFP    = ctrl.start_fp;

`ifdef WRAPPER_IN_BUSY_EN
    assign busy = ctrl.busy;
`else
    // Without the busy feature the completion flag has no consumer.
    logic unused_busy_path;
    assign unused_busy_path = ^{doneFP, ctrl.busy};
    assign busy = 1'b0;
`endif

    wrapper_in_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_a    (ctrl.load_a),
        .load_b    (ctrl.load_b),
        .in_bus    (InBus),
        .operand_a (OperandA),
        .operand_b (OperandB)
    );

endmodule
